// File: rtl/issue_pkg.sv
// Shared issue-stage types: physical register addressing and wakeup requests.
package issue_pkg;

    localparam int PREG_NUM    = 64;
    localparam int FETCH_WIDTH = 4;
    localparam int WAKE_WIDTH  = 4;
    localparam int PREG_W      = $clog2(PREG_NUM);
    localparam int READY_CNT_W = $clog2(PREG_NUM) + 1;

    typedef logic [PREG_W-1:0] preg_addr_t;

    typedef struct packed {
        logic       valid;
        preg_addr_t id;
    } wake_req_t;

endpackage

// File: rtl/preg_ready_lookup.sv
// Source-operand readiness for one rename slot. When PREG_READY_BYPASS_EN is
// defined, same-cycle wakeups are forwarded into the lookup.
module preg_ready_lookup
    import issue_pkg::*;
#(
    parameter int PREG_NUM    = issue_pkg::PREG_NUM,
    parameter int FETCH_WIDTH = issue_pkg::FETCH_WIDTH,
    parameter int WAKE_WIDTH  = issue_pkg::WAKE_WIDTH,
    parameter int SLOT        = 0
) (
    input  logic [PREG_NUM-1:0]                rdy,
    input  preg_addr_t                         psrc,
`ifdef PREG_READY_BYPASS_EN
    input  wake_req_t  [WAKE_WIDTH-1:0]        wake,
`endif
    input  logic       [FETCH_WIDTH-1:0]       alloc_valid,
    input  preg_addr_t [FETCH_WIDTH-1:0]       alloc_pdst,
    input  logic                               alloc_en,
    output logic                               ready
);

    always_comb begin
        ready = rdy[psrc];
`ifdef PREG_READY_BYPASS_EN
        for (int w = 0; w < WAKE_WIDTH; w++) begin
            if (wake[w].valid && wake[w].id == psrc) ready = 1'b1;
        end
`endif
        // An earlier slot producing this preg makes it a fresh, not-yet-ready value.
        // Preg 0 is never a real producer, so it stays ready.
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (k < SLOT && alloc_valid[k] && alloc_en &&
                alloc_pdst[k] == psrc && psrc != '0) ready = 1'b0;
        end
    end

endmodule

// File: rtl/preg_ready_table.sv
// Physical-register ready scoreboard feeding issue. Optional wake->lookup
// forwarding is enabled by defining PREG_READY_BYPASS_EN.
module preg_ready_table
    import issue_pkg::*;
#(
    parameter int PREG_NUM    = issue_pkg::PREG_NUM,
    parameter int FETCH_WIDTH = issue_pkg::FETCH_WIDTH,
    parameter int WAKE_WIDTH  = issue_pkg::WAKE_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  preg_addr_t [FETCH_WIDTH-1:0] psrc1,
    input  preg_addr_t [FETCH_WIDTH-1:0] psrc2,
    output logic       [FETCH_WIDTH-1:0] v1,
    output logic       [FETCH_WIDTH-1:0] v2,
    input  logic       [FETCH_WIDTH-1:0] alloc_valid,
    input  preg_addr_t [FETCH_WIDTH-1:0] alloc_pdst,
    input  logic                         alloc_en,
    input  logic       [WAKE_WIDTH-1:0]  wake_valid,
    input  preg_addr_t [WAKE_WIDTH-1:0]  wake_id,
    input  logic                         flush,
    output logic [READY_CNT_W-1:0]       busy_cnt
);

    logic [PREG_NUM-1:0]    rdy;
    logic [PREG_NUM-1:0]    rdy_nxt;
    logic [PREG_NUM-1:0]    set_v;
    logic [PREG_NUM-1:0]    clr_v;
    logic [READY_CNT_W-1:0] busy_nxt;
    wake_req_t [WAKE_WIDTH-1:0] wake;

    always_comb begin
        for (int w = 0; w < WAKE_WIDTH; w++) begin
            wake[w].valid = wake_valid[w];
            wake[w].id    = wake_id[w];
        end
    end

    // Alloc clears win over wake sets on the same preg: the preg has a new producer.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int w = 0; w < WAKE_WIDTH; w++) begin
            if (wake[w].valid) set_v[wake[w].id] = 1'b1;
        end
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (alloc_valid[k] && alloc_en) clr_v[alloc_pdst[k]] = 1'b1;
        end
        clr_v[0]   = 1'b0;
        rdy_nxt    = (rdy | set_v) & ~clr_v;
        rdy_nxt[0] = 1'b1;
        busy_nxt   = busy_cnt
                   + READY_CNT_W'($countones(rdy & ~rdy_nxt))
                   - READY_CNT_W'($countones(~rdy & rdy_nxt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy      <= '1;
            busy_cnt <= '0;
        end else if (flush) begin
            rdy      <= '1;
            busy_cnt <= '0;
        end else begin
            rdy      <= rdy_nxt;
            busy_cnt <= busy_nxt;
        end
    end

    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
        preg_ready_lookup #(
            .PREG_NUM    (PREG_NUM),
            .FETCH_WIDTH (FETCH_WIDTH),
            .WAKE_WIDTH  (WAKE_WIDTH),
            .SLOT        (i)
        ) u_src1 (
            .rdy         (rdy),
            .psrc        (psrc1[i]),
`ifdef PREG_READY_BYPASS_EN
            .wake        (wake),
`endif
            .alloc_valid (alloc_valid),
            .alloc_pdst  (alloc_pdst),
            .alloc_en    (alloc_en),
            .ready       (v1[i])
        );

        preg_ready_lookup #(
            .PREG_NUM    (PREG_NUM),
            .FETCH_WIDTH (FETCH_WIDTH),
            .WAKE_WIDTH  (WAKE_WIDTH),
            .SLOT        (i)
        ) u_src2 (
            .rdy         (rdy),
            .psrc        (psrc2[i]),
`ifdef PREG_READY_BYPASS_EN
            .wake        (wake),
`endif
            .alloc_valid (alloc_valid),
            .alloc_pdst  (alloc_pdst),
            .alloc_en    (alloc_en),
            .ready       (v2[i])
        );
    end

endmodule

// File: tb/tb_preg_ready_table.sv
// Directed bench for preg_ready_table with hand-computed expectations.
module tb_preg_ready_table;
    import issue_pkg::*;

    logic                  clk;
    logic                  reset;
    preg_addr_t [3:0]      psrc1;
    preg_addr_t [3:0]      psrc2;
    logic       [3:0]      v1;
    logic       [3:0]      v2;
    logic       [3:0]      alloc_valid;
    preg_addr_t [3:0]      alloc_pdst;
    logic                  alloc_en;
    logic       [3:0]      wake_valid;
    preg_addr_t [3:0]      wake_id;
    logic                  flush;
    logic [READY_CNT_W-1:0] busy_cnt;

    int errors = 0;
    int checks = 0;

    preg_ready_table dut (
        .clk         (clk),
        .reset       (reset),
        .psrc1       (psrc1),
        .psrc2       (psrc2),
        .v1          (v1),
        .v2          (v2),
        .alloc_valid (alloc_valid),
        .alloc_pdst  (alloc_pdst),
        .alloc_en    (alloc_en),
        .wake_valid  (wake_valid),
        .wake_id     (wake_id),
        .flush       (flush),
        .busy_cnt    (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        psrc1       = '0;
        psrc2       = '0;
        alloc_valid = '0;
        alloc_pdst  = '0;
        alloc_en    = 1'b0;
        wake_valid  = '0;
        wake_id     = '0;
        flush       = 1'b0;
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        psrc1 = {6'd4, 6'd3, 6'd2, 6'd1};
        psrc2 = {6'd8, 6'd7, 6'd6, 6'd5};
        #12;
        check("reset_v1", v1, 4'b1111);
        check("reset_v2", v2, 4'b1111);
        check("reset_busy", busy_cnt, 0);
        reset = 1'b1;

        // Alloc 7 in slot 0; own slot lookup is unaffected.
        tick();
        idle();
        alloc_valid   = 4'b0001;
        alloc_pdst[0] = 6'd7;
        alloc_en      = 1'b1;
        psrc1[0]      = 6'd7;
        #1;
        check("own_slot_alloc_v1", v1, 4'b1111);
        tick();
        idle();
        psrc1 = {6'd7, 6'd7, 6'd7, 6'd7};
        #1;
        check("alloc7_v1", v1, 4'b0000);
        check("alloc7_busy", busy_cnt, 1);
        tick();
        tick();
        wake_valid = 4'b0100;
        wake_id[2] = 6'd7;
        #1;
`ifdef PREG_READY_BYPASS_EN
        check("wake7_same_cycle", v1, 4'b1111);
`else
        check("wake7_same_cycle", v1, 4'b0000);
`endif
        tick();
        wake_valid = '0;
        #1;
        check("wake7_next_cycle", v1, 4'b1111);
        check("wake7_busy", busy_cnt, 0);

        // Same-group dependency on src2: slot0 allocs 12.
        idle();
        alloc_en      = 1'b1;
        alloc_valid   = 4'b0001;
        alloc_pdst[0] = 6'd12;
        psrc2         = {6'd0, 6'd12, 6'd5, 6'd12};
        #1;
        check("dep_src2", v2, 4'b1011);
        check("dep_src1_clean", v1, 4'b1111);
        tick();
        // Slot2 allocs 13, slot0 allocs preg 0; later reader of 13 blocked, earlier not.
        idle();
        alloc_en      = 1'b1;
        alloc_valid   = 4'b0101;
        alloc_pdst[0] = 6'd0;
        alloc_pdst[2] = 6'd13;
        psrc1         = {6'd13, 6'd13, 6'd13, 6'd0};
        psrc2         = {6'd0, 6'd0, 6'd12, 6'd0};
        #1;
        check("dep_later_only", v1, 4'b0111);
        check("dep_preg0_v2", v2, 4'b1101);
        tick();
        idle();
        #1;
        check("busy_12_13", busy_cnt, 2);
        check("preg0_after_alloc", v1, 4'b1111);

        // Same-cycle alloc and wake of 20: alloc wins.
        alloc_en      = 1'b1;
        alloc_valid   = 4'b0001;
        alloc_pdst[0] = 6'd20;
        wake_valid    = 4'b0010;
        wake_id[1]    = 6'd20;
        tick();
        idle();
        psrc1[0] = 6'd20;
        #1;
        check("alloc_wake_20_v1", v1, 4'b1110);
        check("alloc_wake_20_busy", busy_cnt, 3);

        // Duplicate wakes of 12 and 13 are idempotent.
        wake_valid = 4'b1111;
        wake_id    = {6'd13, 6'd12, 6'd13, 6'd12};
        tick();
        idle();
        psrc1 = {6'd20, 6'd13, 6'd12, 6'd20};
        #1;
        check("dup_wake_v1", v1, 4'b0110);
        check("dup_wake_busy", busy_cnt, 1);

        // Stall: allocs ignored (also in the lookup), wake of 20 still lands.
        alloc_en    = 1'b0;
        alloc_valid = 4'b1111;
        alloc_pdst  = {6'd24, 6'd23, 6'd22, 6'd21};
        wake_valid  = 4'b0001;
        wake_id[0]  = 6'd20;
        psrc1       = {6'd21, 6'd23, 6'd21, 6'd0};
        #1;
        check("stall_no_dep", v1, 4'b1111);
        tick();
        idle();
        psrc1 = {6'd20, 6'd23, 6'd22, 6'd21};
        #1;
        check("stall_v1", v1, 4'b1111);
        check("stall_busy", busy_cnt, 0);

        // Ten busy pregs (31..40), with a preg-0 alloc and a duplicate pdst mixed in.
        alloc_en    = 1'b1;
        alloc_valid = 4'b1111;
        alloc_pdst  = {6'd34, 6'd33, 6'd32, 6'd31};
        tick();
        alloc_pdst  = {6'd38, 6'd37, 6'd36, 6'd35};
        tick();
        alloc_pdst  = {6'd40, 6'd0, 6'd40, 6'd39};
        tick();
        idle();
        psrc1 = {6'd40, 6'd35, 6'd31, 6'd0};
        #1;
        check("ten_busy_cnt", busy_cnt, 10);
        check("ten_busy_v1", v1, 4'b0001);

        // Flush with a concurrent alloc of 30 and a wake.
        flush         = 1'b1;
        alloc_en      = 1'b1;
        alloc_valid   = 4'b0001;
        alloc_pdst[0] = 6'd30;
        wake_valid    = 4'b0001;
        wake_id[0]    = 6'd33;
        tick();
        idle();
        psrc1 = {6'd40, 6'd35, 6'd31, 6'd30};
        #1;
        check("flush_v1", v1, 4'b1111);
        check("flush_busy", busy_cnt, 0);

        // Mid-run asynchronous reset after five allocs.
        alloc_en    = 1'b1;
        alloc_valid = 4'b1111;
        alloc_pdst  = {6'd44, 6'd43, 6'd42, 6'd41};
        tick();
        alloc_valid = 4'b0001;
        alloc_pdst  = {6'd0, 6'd0, 6'd0, 6'd45};
        tick();
        idle();
        psrc1 = {6'd44, 6'd43, 6'd42, 6'd41};
        psrc2 = {6'd0, 6'd0, 6'd0, 6'd45};
        #1;
        check("pre_reset_busy", busy_cnt, 5);
        check("pre_reset_v1", v1, 4'b0000);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_v1", v1, 4'b1111);
        check("async_reset_v2", v2, 4'b1111);
        tick();
        reset = 1'b1;
        tick();
        #1;
        check("post_reset_busy", busy_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
